// File: rtl/nq_arbiter.sv
// nq_arbiter
// Two-port round-robin arbiter and sequencer for the NaughtyQ replacement list.
// Grants one of two clients (A, B) per operation, drives the queue's
// enable/command/ready handshake, inserts the one-cycle enable drop the queue
// needs to re-arm, returns the captured result with a done pulse to the
// requester that owned the op, and latches a sticky fault on crash or timeout.
//
// Ports:
//   clock, reset                 system clock, async active-high reset
//   a_req/a_cmd/a_idx/a_data     client A request (held until a_done)
//   b_req/b_cmd/b_idx/b_data     client B request (held until b_done)
//   a_done, b_done               one-cycle completion pulses
//   rsp_idx, rsp_data            queue outputs captured at completion
//   nq_enable/nq_command/nq_idx/nq_data  queue control and operands
//   nq_ready, nq_crashed         queue status
//   nq_idx_out, nq_data_out      queue results
//   fault                        sticky crash/timeout indication
//   op_count                     completed operations, wraps at 16 bits
module nq_arbiter #(
  parameter int IDX_WIDTH  = 3,
  parameter int DATA_WIDTH = 8,
  parameter int CMD_WIDTH  = 2,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic [CMD_WIDTH-1:0]  a_cmd,
  input  logic [IDX_WIDTH-1:0]  a_idx,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  b_req,
  input  logic [CMD_WIDTH-1:0]  b_cmd,
  input  logic [IDX_WIDTH-1:0]  b_idx,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  a_done,
  output logic                  b_done,
  output logic [IDX_WIDTH-1:0]  rsp_idx,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  nq_enable,
  output logic [CMD_WIDTH:0]    nq_command,
  output logic [IDX_WIDTH-1:0]  nq_idx,
  output logic [DATA_WIDTH-1:0] nq_data,
  input  logic                  nq_ready,
  input  logic                  nq_crashed,
  input  logic [IDX_WIDTH-1:0]  nq_idx_out,
  input  logic [DATA_WIDTH-1:0] nq_data_out,
  output logic                  fault,
  output logic [15:0]           op_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2,
    ST_FAULT  = 2'd3
  } state_t;

  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;
  // Last timer value that may still see nq_ready; one more miss faults.
  localparam logic [3:0] TIMEOUT_LAST = 4'(TIMEOUT - 1);

  state_t                  state_r, state_s;
  logic                    last_grant_r, last_grant_s;
  logic                    grantee_r, grantee_s;
  logic                    pick_b_s;
  logic [3:0]              timer_r, timer_s;
  logic                    enable_r, enable_s;
  logic [CMD_WIDTH:0]      command_r, command_s;
  logic [IDX_WIDTH-1:0]    idx_r, idx_s;
  logic [DATA_WIDTH-1:0]   data_r, data_s;
  logic                    a_done_r, a_done_s;
  logic                    b_done_r, b_done_s;
  logic [IDX_WIDTH-1:0]    rsp_idx_r, rsp_idx_s;
  logic [DATA_WIDTH-1:0]   rsp_data_r, rsp_data_s;
  logic                    fault_r, fault_s;
  logic [15:0]             op_count_r, op_count_s;

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_s      = state_r;
    last_grant_s = last_grant_r;
    grantee_s    = grantee_r;
    pick_b_s     = 1'b0;
    timer_s      = timer_r;
    enable_s     = enable_r;
    command_s    = command_r;
    idx_s        = idx_r;
    data_s       = data_r;
    a_done_s     = 1'b0;
    b_done_s     = 1'b0;
    rsp_idx_s    = rsp_idx_r;
    rsp_data_s   = rsp_data_r;
    fault_s      = fault_r;
    op_count_s   = op_count_r;

    case (state_r)
      ST_IDLE: begin
        if (nq_crashed) begin
          state_s  = ST_FAULT;
          fault_s  = 1'b1;
          enable_s = 1'b0;
        end else if (a_req || b_req) begin
          // B wins only if A is idle or A had the previous grant.
          pick_b_s = b_req && (!a_req || (last_grant_r == GRANT_A));
          if (pick_b_s) begin
            command_s = {1'b0, b_cmd};
            idx_s     = b_idx;
            data_s    = b_data;
          end else begin
            command_s = {1'b0, a_cmd};
            idx_s     = a_idx;
            data_s    = a_data;
          end
          grantee_s    = pick_b_s;
          last_grant_s = pick_b_s;
          timer_s      = 4'd0;
          enable_s     = 1'b1;
          state_s      = ST_ACTIVE;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_ACTIVE: begin
        if (nq_crashed) begin
          // Crash outranks a same-cycle ready: no completion is reported.
          state_s  = ST_FAULT;
          fault_s  = 1'b1;
          enable_s = 1'b0;
        end else if (nq_ready) begin
          rsp_idx_s  = nq_idx_out;
          rsp_data_s = nq_data_out;
          enable_s   = 1'b0;
          op_count_s = op_count_r + 16'd1;
          if (grantee_r == GRANT_B) begin
            b_done_s = 1'b1;
          end else begin
            a_done_s = 1'b1;
          end
          state_s = ST_DONE;
        end else if (timer_r == TIMEOUT_LAST) begin
          state_s  = ST_FAULT;
          fault_s  = 1'b1;
          enable_s = 1'b0;
        end else begin
          timer_s = timer_r + 4'd1;
        end
      end

      ST_DONE: begin
        // Enable is already low here; this cycle lets the queue re-arm.
        if (nq_crashed) begin
          state_s  = ST_FAULT;
          fault_s  = 1'b1;
          enable_s = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_FAULT: begin
        state_s  = ST_FAULT;
        fault_s  = 1'b1;
        enable_s = 1'b0;
      end

      default: begin
        state_s  = ST_FAULT;
        fault_s  = 1'b1;
        enable_s = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Registered outputs and grant bookkeeping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant_r <= GRANT_B;
      grantee_r    <= GRANT_A;
      timer_r      <= 4'd0;
      enable_r     <= 1'b0;
      command_r    <= '0;
      idx_r        <= '0;
      data_r       <= '0;
      a_done_r     <= 1'b0;
      b_done_r     <= 1'b0;
      rsp_idx_r    <= '0;
      rsp_data_r   <= '0;
      fault_r      <= 1'b0;
      op_count_r   <= 16'd0;
    end else begin
      last_grant_r <= last_grant_s;
      grantee_r    <= grantee_s;
      timer_r      <= timer_s;
      enable_r     <= enable_s;
      command_r    <= command_s;
      idx_r        <= idx_s;
      data_r       <= data_s;
      a_done_r     <= a_done_s;
      b_done_r     <= b_done_s;
      rsp_idx_r    <= rsp_idx_s;
      rsp_data_r   <= rsp_data_s;
      fault_r      <= fault_s;
      op_count_r   <= op_count_s;
    end
  end

  assign nq_enable  = enable_r;
  assign nq_command = command_r;
  assign nq_idx     = idx_r;
  assign nq_data    = data_r;
  assign a_done     = a_done_r;
  assign b_done     = b_done_r;
  assign rsp_idx    = rsp_idx_r;
  assign rsp_data   = rsp_data_r;
  assign fault      = fault_r;
  assign op_count   = op_count_r;

endmodule

// File: tb/tb_nq_arbiter.sv
// Self-checking bench for nq_arbiter: a stub queue answers the handshake,
// stimulus pushes expected results per port, and a monitor pops and compares
// on every done pulse while also predicting round-robin grants and op_count.
module tb_nq_arbiter;
  localparam int IW = 3;
  localparam int DW = 8;
  typedef logic [IW+DW-1:0] rsp_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          a_req, b_req;
  logic [1:0]    a_cmd, b_cmd;
  logic [IW-1:0] a_idx, b_idx;
  logic [DW-1:0] a_data, b_data;
  logic          a_done, b_done;
  logic [IW-1:0] rsp_idx;
  logic [DW-1:0] rsp_data;
  logic          nq_enable;
  logic [2:0]    nq_command;
  logic [IW-1:0] nq_idx;
  logic [DW-1:0] nq_data;
  logic          nq_ready, nq_crashed;
  logic [IW-1:0] nq_idx_out;
  logic [DW-1:0] nq_data_out;
  logic          fault;
  logic [15:0]   op_count;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   hold_ready = 1'b0;
  rsp_t qa[$];
  rsp_t qb[$];

  nq_arbiter dut (
    .clock(clock), .reset(reset),
    .a_req(a_req), .a_cmd(a_cmd), .a_idx(a_idx), .a_data(a_data),
    .b_req(b_req), .b_cmd(b_cmd), .b_idx(b_idx), .b_data(b_data),
    .a_done(a_done), .b_done(b_done), .rsp_idx(rsp_idx), .rsp_data(rsp_data),
    .nq_enable(nq_enable), .nq_command(nq_command), .nq_idx(nq_idx), .nq_data(nq_data),
    .nq_ready(nq_ready), .nq_crashed(nq_crashed),
    .nq_idx_out(nq_idx_out), .nq_data_out(nq_data_out),
    .fault(fault), .op_count(op_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // What the stub queue returns for an operation.
  function automatic rsp_t q_resp(input logic [1:0] cmd, input logic [IW-1:0] idx,
                                  input logic [DW-1:0] data);
    case (cmd)
      2'd1:    return {3'd7, data};
      2'd2:    return {idx, ~data};
      2'd3:    return {idx, data + 8'h11};
      default: return '0;
    endcase
  endfunction

  // Stub queue: ready one cycle after it first sees enable, drops with enable.
  initial begin
    bit en_prev;
    en_prev = 1'b0;
    nq_ready = 1'b0;
    nq_idx_out = '0;
    nq_data_out = '0;
    forever begin
      @(posedge clock); #1;
      if (reset) begin
        nq_ready = 1'b0;
        en_prev = 1'b0;
      end else begin
        nq_ready = nq_enable && en_prev && !hold_ready;
        if (nq_ready) {nq_idx_out, nq_data_out} = q_resp(nq_command[1:0], nq_idx, nq_data);
        en_prev = nq_enable;
      end
    end
  end

  // Monitor: predicts grants, pops the owning port's queue on each done.
  initial begin
    int   exp_cnt;
    bit   last_b, cur_b, prev_en, pa_req, pb_req;
    logic [1:0] pa_cmd, pb_cmd;
    logic [IW-1:0] pa_idx, pb_idx;
    logic [DW-1:0] pa_data, pb_data;
    rsp_t r;
    exp_cnt = 0; last_b = 1'b1; cur_b = 1'b0; prev_en = 1'b0;
    pa_req = 1'b0; pb_req = 1'b0;
    pa_cmd = '0; pb_cmd = '0; pa_idx = '0; pb_idx = '0; pa_data = '0; pb_data = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        exp_cnt = 0; last_b = 1'b1; qa.delete(); qb.delete();
      end else begin
        if (nq_enable && !prev_en) begin
          chk("grant_had_req", 32'(pa_req | pb_req), 32'd1);
          cur_b = pb_req && (!pa_req || !last_b);
          last_b = cur_b;
          chk("grant_cmd", 32'(nq_command), cur_b ? 32'({1'b0, pb_cmd}) : 32'({1'b0, pa_cmd}));
          chk("grant_idx", 32'(nq_idx), cur_b ? 32'(pb_idx) : 32'(pa_idx));
          chk("grant_data", 32'(nq_data), cur_b ? 32'(pb_data) : 32'(pa_data));
        end
        if (a_done || b_done) begin
          chk("single_done", 32'(a_done & b_done), 32'd0);
          chk("done_port", 32'(b_done), 32'(cur_b));
          if (b_done) begin
            chk("b_done_expected", 32'(qb.size() != 0), 32'd1);
            if (qb.size() != 0) begin
              r = qb.pop_front();
              chk("b_rsp", 32'({rsp_idx, rsp_data}), 32'(r));
            end
          end else begin
            chk("a_done_expected", 32'(qa.size() != 0), 32'd1);
            if (qa.size() != 0) begin
              r = qa.pop_front();
              chk("a_rsp", 32'({rsp_idx, rsp_data}), 32'(r));
            end
          end
          exp_cnt = (exp_cnt + 1) % 65536;
          chk("op_count", 32'(op_count), 32'(exp_cnt));
        end
      end
      prev_en = nq_enable;
      pa_req = a_req; pb_req = b_req;
      pa_cmd = a_cmd; pb_cmd = b_cmd;
      pa_idx = a_idx; pb_idx = b_idx;
      pa_data = a_data; pb_data = b_data;
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic issue_a(input logic [1:0] c, input logic [IW-1:0] i, input logic [DW-1:0] d);
    a_cmd = c; a_idx = i; a_data = d; a_req = 1'b1;
    qa.push_back(q_resp(c, i, d));
  endtask

  task automatic issue_b(input logic [1:0] c, input logic [IW-1:0] i, input logic [DW-1:0] d);
    b_cmd = c; b_idx = i; b_data = d; b_req = 1'b1;
    qb.push_back(q_resp(c, i, d));
  endtask

  task automatic wait_done(input bit port_b);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (port_b ? b_done : a_done) begin
        ok = 1'b1;
        break;
      end
    end
    chk(port_b ? "b_done_timeout" : "a_done_timeout", 32'(ok), 32'd1);
  endtask

  task automatic rand_port(input bit port_b, input int n);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
      if (port_b) issue_b(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
      else        issue_a(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
      wait_done(port_b);
      if (port_b) b_req = 1'b0; else a_req = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int na, nb, ta, tb, tprev, en_cnt, dn_cnt;
    bit got;
    reset = 1'b1; nq_crashed = 1'b0;
    a_req = 1'b0; b_req = 1'b0;
    a_cmd = '0; b_cmd = '0; a_idx = '0; b_idx = '0; a_data = '0; b_data = '0;
    do_reset();

    // Reset values, then a single ENLIST from A.
    chk("rst_outputs", 32'({nq_enable, nq_command, nq_idx, nq_data, a_done, b_done, fault}), 32'd0);
    chk("rst_rsp", 32'({rsp_idx, rsp_data}), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    issue_a(2'd1, 3'd0, 8'h5A);
    @(posedge clock);
    @(negedge clock);
    chk("e0_enable", 32'(nq_enable), 32'd1);
    chk("e0_command", 32'(nq_command), 32'd1);
    @(negedge clock);
    chk("e1_enable", 32'(nq_enable), 32'd1);
    chk("e1_a_done", 32'(a_done), 32'd0);
    @(negedge clock);
    chk("e2_enable", 32'(nq_enable), 32'd0);
    chk("e2_a_done", 32'(a_done), 32'd1);
    chk("e2_rsp_idx", 32'(rsp_idx), 32'd7);
    chk("e2_op_count", 32'(op_count), 32'd1);
    a_req = 1'b0;
    @(negedge clock);
    chk("e3_a_done", 32'(a_done), 32'd0);

    // Both held with READDATA: strict alternation A,B,A,B, 4 cycles apart.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      qa.push_back(q_resp(2'd3, 3'd1, 8'h10));
      qb.push_back(q_resp(2'd3, 3'd6, 8'h60));
    end
    a_cmd = 2'd3; a_idx = 3'd1; a_data = 8'h10;
    b_cmd = 2'd3; b_idx = 3'd6; b_data = 8'h60;
    a_req = 1'b1; b_req = 1'b1;
    tprev = 0;
    for (int k = 0; k < 8; k++) begin
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(posedge clock); #1;
        if (a_done || b_done) begin got = 1'b1; break; end
      end
      chk("alt_done_seen", 32'(got), 32'd1);
      if (!got) break;
      chk("alt_port", 32'(b_done), 32'(k % 2));
      chk("alt_enable_low", 32'(nq_enable), 32'd0);
      if (k > 0) chk("alt_gap", 32'(cyc - tprev), 32'd4);
      tprev = cyc;
    end
    a_req = 1'b0; b_req = 1'b0;

    // BACKOFQUEUE from B, then ENLIST from A: B completes first, each once.
    do_reset();
    issue_b(2'd2, 3'd4, 8'h3C);
    @(posedge clock); #1;
    issue_a(2'd1, 3'd0, 8'h77);
    na = 0; nb = 0; ta = 0; tb = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clock); #1;
      if (b_done) begin nb++; tb = i; b_req = 1'b0; end
      if (a_done) begin
        na++; ta = i; a_req = 1'b0;
        chk("enlist_tail", 32'(rsp_idx), 32'd7);
      end
    end
    chk("boq_b_once", 32'(nb), 32'd1);
    chk("boq_a_once", 32'(na), 32'd1);
    chk("boq_b_first", 32'(tb < ta), 32'd1);

    // Randomized traffic from both clients.
    do_reset();
    fork
      rand_port(1'b0, 25);
      rand_port(1'b1, 25);
    join

    // Queue never answers: fault after 15 ACTIVE cycles, then deaf.
    do_reset();
    hold_ready = 1'b1;
    issue_a(2'd3, 3'd5, 8'hC3);
    @(posedge clock);
    repeat (15) @(negedge clock);
    chk("to_fault_early", 32'(fault), 32'd0);
    chk("to_enable_held", 32'(nq_enable), 32'd1);
    @(negedge clock);
    chk("to_fault", 32'(fault), 32'd1);
    chk("to_enable_off", 32'(nq_enable), 32'd0);
    hold_ready = 1'b0;
    b_req = 1'b1;
    en_cnt = 0; dn_cnt = 0;
    repeat (10) begin
      @(negedge clock);
      en_cnt += int'(nq_enable);
      dn_cnt += int'(a_done | b_done);
    end
    chk("to_no_enable", 32'(en_cnt), 32'd0);
    chk("to_no_done", 32'(dn_cnt), 32'd0);
    chk("to_fault_sticky", 32'(fault), 32'd1);
    a_req = 1'b0; b_req = 1'b0;
    do_reset();
    chk("to_fault_cleared", 32'(fault), 32'd0);

    // Crash while idle with a pending request: fault, no grant.
    nq_crashed = 1'b1;
    a_cmd = 2'd1; a_req = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("crash_fault", 32'(fault), 32'd1);
    en_cnt = 0; dn_cnt = 0;
    repeat (5) begin
      @(negedge clock);
      en_cnt += int'(nq_enable);
      dn_cnt += int'(a_done | b_done);
    end
    chk("crash_no_enable", 32'(en_cnt), 32'd0);
    chk("crash_no_done", 32'(dn_cnt), 32'd0);
    nq_crashed = 1'b0; a_req = 1'b0;
    do_reset();
    chk("crash_cleared", 32'(fault), 32'd0);

    // Reset in ACTIVE: outputs zero at once, op abandoned, re-grant after.
    @(posedge clock); #1;
    issue_a(2'd1, 3'd2, 8'h42);
    wait_done(1'b0);
    issue_a(2'd3, 3'd2, 8'h33);
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (nq_enable) begin got = 1'b1; break; end
    end
    chk("mid_grant_seen", 32'(got), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_enable", 32'(nq_enable), 32'd0);
    chk("mid_rst_cmd", 32'({nq_command, nq_idx, nq_data}), 32'd0);
    chk("mid_rst_op_count", 32'(op_count), 32'd0);
    chk("mid_rst_done", 32'({a_done, b_done}), 32'd0);
    @(posedge clock); #1;
    chk("mid_rst_no_done", 32'({a_done, b_done}), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    qa.push_back(q_resp(2'd3, 3'd2, 8'h33));
    wait_done(1'b0);
    chk("mid_regrant_count", 32'(op_count), 32'd1);
    a_req = 1'b0;
    repeat (4) @(posedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
